// File: rtl/mmio_bridge_if.sv
// LSU request/response and RAM channel bundle for mmio_bridge.
// slave = bridge view, master = LSU/RAM environment view.
interface mmio_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  ram_req_valid;
    logic                  ram_req_ready;
    logic                  ram_wen;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W/8-1:0]   ram_wmask;
    logic                  ram_rsp_valid;
    logic [DATA_W-1:0]     ram_rdata;

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
               ram_req_ready, ram_rsp_valid, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               ram_req_valid, ram_wen, ram_addr, ram_wdata, ram_wmask
    );

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
               ram_req_ready, ram_rsp_valid, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               ram_req_valid, ram_wen, ram_addr, ram_wdata, ram_wmask
    );
endinterface

// File: rtl/mmio_bridge.sv
// MMIO decoder: LSU -> external RAM, keyboard scancode FIFO, seven-segment register.
// Define MMIO_TIMEOUT_EN to enable the RAM wait timeout counter.
module mmio_bridge #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 64,
    parameter int              KB_W     = 8,
    parameter int              KB_DEPTH = 8,
    parameter int              SEG_W    = 32,
    parameter logic [ADDR_W-1:0] RAM_BASE = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] RAM_LEN  = 32'h0800_0000,
    parameter logic [ADDR_W-1:0] KB_BASE  = 32'ha000_0060,
    parameter logic [ADDR_W-1:0] SEG_BASE = 32'ha000_0100,
    parameter int              PERI_LEN = 8,
    parameter int              TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    mmio_bridge_if.slave      bus,
    input  logic              kb_push,
    input  logic [KB_W-1:0]   kb_data,
    output logic              kb_full,
    output logic [SEG_W-1:0]  seg_wdata
);
    localparam int PTR_W = $clog2(KB_DEPTH);

    typedef enum logic [1:0] {IDLE, RAM_REQ, RAM_WAIT, RESP} state_t;
    state_t state;

    // Window test done one bit wider so base+len never wraps.
    function automatic logic in_win(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] len);
        logic [ADDR_W:0] lo, hi, x;
        lo = {1'b0, base};
        hi = lo + {1'b0, len};
        x  = {1'b0, a};
        return (x >= lo) && (x < hi);
    endfunction

    logic accept, hit_ram, hit_kb, hit_kb_data, hit_seg;
    assign accept      = (state == IDLE) && bus.req_valid && bus.req_ready;
    assign hit_ram     = in_win(bus.req_addr, RAM_BASE, RAM_LEN);
    assign hit_kb      = in_win(bus.req_addr, KB_BASE, ADDR_W'(PERI_LEN));
    assign hit_kb_data = in_win(bus.req_addr, KB_BASE, ADDR_W'(4));
    assign hit_seg     = in_win(bus.req_addr, SEG_BASE, ADDR_W'(PERI_LEN));

    logic [KB_W-1:0]  kb_mem [KB_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr, kb_count;
    logic             kb_empty, do_push, do_pop;
    assign kb_count = wr_ptr - rd_ptr;
    assign kb_empty = (kb_count == '0);
    assign kb_full  = (kb_count == (PTR_W+1)'(KB_DEPTH));
    assign do_push  = kb_push && !kb_full;
    assign do_pop   = accept && hit_kb_data && !bus.req_wen && !kb_empty;

    always_ff @(posedge clk) begin
        if (do_push) kb_mem[wr_ptr[PTR_W-1:0]] <= kb_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // KB offsets below +4 read the data port; the rest of the window is status.
    logic [DATA_W-1:0] peri_rdata;
    logic              peri_err;
    always_comb begin
        peri_rdata = '0;
        peri_err   = 1'b0;
        if (hit_kb) begin
            if (bus.req_wen)      peri_err   = 1'b1;
            else if (hit_kb_data) peri_rdata = kb_empty ? '0 : DATA_W'(kb_mem[rd_ptr[PTR_W-1:0]]);
            else                  peri_rdata = DATA_W'({kb_full, kb_count});
        end else if (hit_seg) begin
            if (!bus.req_wen)     peri_rdata = DATA_W'(seg_wdata);
        end else begin
            peri_err = 1'b1;
        end
    end

    logic tmo_hit;
`ifdef MMIO_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TMO_W-1:0] tmo_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      tmo_cnt <= '0;
        else if (state == RAM_REQ || state == RAM_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
        else                                          tmo_cnt <= '0;
    end
    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            bus.req_ready     <= 1'b0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_rdata     <= '0;
            bus.rsp_err       <= 1'b0;
            bus.ram_req_valid <= 1'b0;
            bus.ram_wen       <= 1'b0;
            bus.ram_addr      <= '0;
            bus.ram_wdata     <= '0;
            bus.ram_wmask     <= '0;
            seg_wdata         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        if (hit_ram) begin
                            bus.ram_req_valid <= 1'b1;
                            bus.ram_wen       <= bus.req_wen;
                            bus.ram_addr      <= bus.req_addr;
                            bus.ram_wdata     <= bus.req_wdata;
                            bus.ram_wmask     <= bus.req_wmask;
                            state             <= RAM_REQ;
                        end else begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rdata <= peri_rdata;
                            bus.rsp_err   <= peri_err;
                            state         <= RESP;
                            if (hit_seg && bus.req_wen) begin
                                for (int unsigned i = 0; i < SEG_W/8; i++) begin
                                    if (bus.req_wmask[i]) seg_wdata[i*8 +: 8] <= bus.req_wdata[i*8 +: 8];
                                end
                            end
                        end
                    end
                end
                RAM_REQ: begin
                    if (tmo_hit) begin
                        bus.ram_req_valid <= 1'b0;
                        bus.rsp_valid     <= 1'b1;
                        bus.rsp_rdata     <= '0;
                        bus.rsp_err       <= 1'b1;
                        state             <= RESP;
                    end else if (bus.ram_req_ready) begin
                        bus.ram_req_valid <= 1'b0;
                        state             <= RAM_WAIT;
                    end
                end
                RAM_WAIT: begin
                    if (tmo_hit) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b1;
                        state         <= RESP;
                    end else if (bus.ram_rsp_valid) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= bus.ram_wen ? '0 : bus.ram_rdata;
                        bus.rsp_err   <= 1'b0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// Directed self-checking bench for mmio_bridge: vector table plus RAM, FIFO and reset sequences.
module tb_mmio_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kb_push = 1'b0;
    logic [7:0]  kb_data = '0;
    logic        kb_full;
    logic [31:0] seg_wdata;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mmio_bridge_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    mmio_bridge #(.ADDR_W(32), .DATA_W(64), .KB_W(8), .KB_DEPTH(8), .SEG_W(32)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .kb_push(kb_push), .kb_data(kb_data), .kb_full(kb_full), .seg_wdata(seg_wdata)
    );

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_seg;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        kb_push = 1'b1;
        kb_data = d;
        @(negedge clk);
        kb_push = 1'b0;
    endtask

    // Peripheral/error transaction; optional scancode push lands on the accept edge.
    task automatic txn(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wmask, input logic push_now, input logic [7:0] push_val,
                       output logic [63:0] rdata, output logic err, output int lat);
        int n;
        rdata = '1;
        err   = 1'bx;
        lat   = -1;
        @(negedge clk);
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wmask = wmask;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_bound", 64'd0, 64'd1);
            bus.req_valid = 1'b0;
            return;
        end
        if (push_now) begin
            kb_push = 1'b1;
            kb_data = push_val;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        kb_push       = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) begin
            chk("rsp_bound", 64'd0, 64'd1);
            return;
        end
        lat   = n;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic ram_start(input logic wen, input logic [31:0] addr,
                             input logic [63:0] wdata, input logic [7:0] wmask);
        @(negedge clk);
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wmask = wmask;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          n;
        logic        seen;

        bus.req_valid = 0; bus.req_wen = 0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wmask = '0;
        bus.rsp_ready = 0; bus.ram_req_ready = 0; bus.ram_rsp_valid = 0; bus.ram_rdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_ram_req_valid", {63'd0, bus.ram_req_valid}, 64'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
        chk("rst_kb_full", {63'd0, kb_full}, 64'd0);
        chk("rst_seg", {32'd0, seg_wdata}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", {63'd0, bus.req_ready}, 64'd1);

        // Reset during RAM_REQ drops ram_req_valid without a clock edge
        ram_start(1'b0, 32'h8000_0040, '0, '0);
        chk("ramreq_valid", {63'd0, bus.ram_req_valid}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_ram_req_drop", {63'd0, bus.ram_req_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset during RAM_WAIT, then a stale RAM response must not produce rsp_valid
        ram_start(1'b0, 32'h8000_0040, '0, '0);
        bus.ram_req_ready = 1'b1;
        @(negedge clk);
        bus.ram_req_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstwait_outputs", {59'd0, bus.rsp_valid, bus.req_ready, bus.ram_req_valid, bus.rsp_err, kb_full}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.ram_rsp_valid = 1'b1;
        bus.ram_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        bus.ram_rsp_valid = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            if (bus.rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("no_rsp_after_reset", {63'd0, seen}, 64'd0);

        // RAM read with request stall, 3-cycle RAM latency and LSU backpressure
        ram_start(1'b0, 32'h8000_0010, '0, '0);
        chk("rd_ram_addr", {32'd0, bus.ram_addr}, 64'h8000_0010);
        chk("rd_ram_wen", {63'd0, bus.ram_wen}, 64'd0);
        chk("rd_req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
        @(negedge clk);
        chk("rd_stall_valid", {63'd0, bus.ram_req_valid}, 64'd1);
        bus.ram_req_ready = 1'b1;
        @(negedge clk);
        bus.ram_req_ready = 1'b0;
        chk("rd_wait_valid_low", {63'd0, bus.ram_req_valid}, 64'd0);
        repeat (2) @(negedge clk);
        chk("rd_no_early_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        bus.ram_rsp_valid = 1'b1;
        bus.ram_rdata = 64'hDEAD_BEEF_0123_4567;
        @(negedge clk);
        bus.ram_rsp_valid = 1'b0;
        bus.ram_rdata = '0;
        repeat (2) begin
            chk("rd_hold_valid", {63'd0, bus.rsp_valid}, 64'd1);
            chk("rd_hold_rdata", bus.rsp_rdata, 64'hDEAD_BEEF_0123_4567);
            chk("rd_hold_err", {63'd0, bus.rsp_err}, 64'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rd_done_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rd_done_ready", {63'd0, bus.req_ready}, 64'd1);

        // RAM write: fields forwarded, response data forced to zero
        ram_start(1'b1, 32'h8000_0020, 64'h1122_3344_5566_7788, 8'hF0);
        chk("wr_ram_fields", {bus.ram_wen, 23'd0, bus.ram_wmask, bus.ram_addr}, {1'b1, 23'd0, 8'hF0, 32'h8000_0020});
        chk("wr_ram_wdata", bus.ram_wdata, 64'h1122_3344_5566_7788);
        bus.ram_req_ready = 1'b1;
        @(negedge clk);
        bus.ram_req_ready = 1'b0;
        bus.ram_rsp_valid = 1'b1;
        bus.ram_rdata = '1;
        @(negedge clk);
        bus.ram_rsp_valid = 1'b0;
        chk("wr_rsp", {bus.rsp_valid, bus.rsp_err, 62'd0}, {1'b1, 1'b0, 62'd0});
        chk("wr_rsp_rdata", bus.rsp_rdata, 64'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;

        // Peripheral vector table
        push(8'h1C);
        push(8'hF0);
        push(8'h1C);
        vecs.push_back('{1'b0, 32'ha000_0064, 64'h0, 8'h00, 64'h3,  1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'ha000_0060, 64'h0, 8'h00, 64'h1C, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'ha000_0060, 64'h0, 8'h00, 64'hF0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'ha000_0060, 64'h0, 8'h00, 64'h1C, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'ha000_0060, 64'h0, 8'h00, 64'h0,  1'b0, 32'h0});
        vecs.push_back('{1'b0, 32'ha000_0064, 64'h0, 8'h00, 64'h0,  1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'ha000_0100, 64'h1234_5678, 8'h0F, 64'h0, 1'b0, 32'h1234_5678});
        vecs.push_back('{1'b1, 32'ha000_0100, 64'hAA, 8'h01, 64'h0, 1'b0, 32'h1234_56AA});
        vecs.push_back('{1'b0, 32'ha000_0100, 64'h0, 8'h00, 64'h1234_56AA, 1'b0, 32'h1234_56AA});
        vecs.push_back('{1'b0, 32'ha000_0107, 64'h0, 8'h00, 64'h1234_56AA, 1'b0, 32'h1234_56AA});
        vecs.push_back('{1'b0, 32'ha000_0108, 64'h0, 8'h00, 64'h0, 1'b1, 32'h1234_56AA});
        vecs.push_back('{1'b0, 32'h1000_0000, 64'h0, 8'h00, 64'h0, 1'b1, 32'h1234_56AA});
        vecs.push_back('{1'b1, 32'ha000_0060, 64'h55, 8'hFF, 64'h0, 1'b1, 32'h1234_56AA});
        vecs.push_back('{1'b1, 32'ha000_0064, 64'h55, 8'hFF, 64'h0, 1'b1, 32'h1234_56AA});
        vecs.push_back('{1'b0, 32'ha000_005F, 64'h0, 8'h00, 64'h0, 1'b1, 32'h1234_56AA});
        vecs.push_back('{1'b0, 32'ha000_0068, 64'h0, 8'h00, 64'h0, 1'b1, 32'h1234_56AA});
        vecs.push_back('{1'b0, 32'h8800_0000, 64'h0, 8'h00, 64'h0, 1'b1, 32'h1234_56AA});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 64'h0, 8'h00, 64'h0, 1'b1, 32'h1234_56AA});
        vecs.push_back('{1'b0, 32'ha000_0064, 64'h0, 8'h00, 64'h0, 1'b0, 32'h1234_56AA});
        vecs.push_back('{1'b1, 32'ha000_0104, 64'hFFFF_FFFF_0000_BB00, 8'hF2, 64'h0, 1'b0, 32'h1234_BBAA});
        for (int i = 0; i < vecs.size(); i++) begin
            txn(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, 1'b0, 8'h00, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {63'd0, er}, {63'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_seg", i), {32'd0, seg_wdata}, {32'd0, vecs[i].exp_seg});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd0);
        end

        // FIFO overflow: ninth scancode dropped
        for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
        chk("fifo_full", {63'd0, kb_full}, 64'd1);
        txn(1'b0, 32'ha000_0064, '0, '0, 1'b0, 8'h00, rd, er, lat);
        chk("fifo_full_status", rd, 64'h18);
        for (int i = 0; i < 8; i++) begin
            txn(1'b0, 32'ha000_0060, '0, '0, 1'b0, 8'h00, rd, er, lat);
            chk($sformatf("fifo_pop%0d", i), rd, 64'h10 + 64'(i));
        end
        txn(1'b0, 32'ha000_0060, '0, '0, 1'b0, 8'h00, rd, er, lat);
        chk("fifo_drop_9th", rd, 64'h0);
        chk("fifo_not_full", {63'd0, kb_full}, 64'd0);

        // Same-cycle push and pop: empty case returns 0, non-empty keeps count
        txn(1'b0, 32'ha000_0060, '0, '0, 1'b1, 8'h77, rd, er, lat);
        chk("pushpop_empty", {rd[62:0], er}, 64'h0);
        txn(1'b0, 32'ha000_0064, '0, '0, 1'b0, 8'h00, rd, er, lat);
        chk("pushpop_empty_count", rd, 64'h1);
        txn(1'b0, 32'ha000_0060, '0, '0, 1'b1, 8'h78, rd, er, lat);
        chk("pushpop_data", rd, 64'h77);
        txn(1'b0, 32'ha000_0064, '0, '0, 1'b0, 8'h00, rd, er, lat);
        chk("pushpop_count", rd, 64'h1);
        txn(1'b0, 32'ha000_0060, '0, '0, 1'b0, 8'h00, rd, er, lat);
        chk("pushpop_second", rd, 64'h78);

`ifdef MMIO_TIMEOUT_EN
        // RAM accepts but never answers
        ram_start(1'b0, 32'h8000_0080, '0, '0);
        bus.ram_req_ready = 1'b1;
        n = 0;
        while (!bus.rsp_valid && n < 400) begin
            @(negedge clk);
            bus.ram_req_ready = 1'b0;
            n++;
        end
        chk("tmo_window", {63'd0, (n >= 250 && n <= 262)}, 64'd1);
        chk("tmo_err", {63'd0, bus.rsp_err}, 64'd1);
        chk("tmo_rdata", bus.rsp_rdata, 64'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.ram_rsp_valid = 1'b1;
        @(negedge clk);
        bus.ram_rsp_valid = 1'b0;
        @(negedge clk);
        chk("tmo_late_ignored", {63'd0, bus.rsp_valid}, 64'd0);
`else
        n = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
Parametrised MMIO decoder between the core's load/store unit and three targets: external RAM, an internal keyboard scancode FIFO, and a seven-segment data register. Uses valid/ready handshakes on the request and response channels. Decodes one transaction at a time and returns read data or an error response. Sits between the LSU and the RAM/peripheral wrappers, replacing the combinational decode path.

Parameters:
ADDR_W, 32, request address width
DATA_W, 64, data width; byte mask is DATA_W/8 bits
KB_W, 8, scancode width
KB_DEPTH, 8, keyboard FIFO entries; power of two, at least 2
SEG_W, 32, segment register width; at most DATA_W
RAM_BASE, 32'h8000_0000, RAM window base
RAM_LEN, 32'h0800_0000, RAM window length in bytes
KB_BASE, 32'h a000_0060, keyboard window base; +0 data, +4 status
SEG_BASE, 32'h a000_0100, segment window base
PERI_LEN, 8, peripheral window length in bytes
TIMEOUT, 255, RAM wait limit in cycles

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  LSU request valid
req_ready  out  1  bridge accepts request
req_wen  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data
req_wmask  in  DATA_W/8  byte enables for writes
rsp_valid  out  1  response valid
rsp_ready  in  1  LSU accepts response
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  decode miss, timeout, or write to read-only location
ram_req_valid  out  1  RAM request valid
ram_req_ready  in  1  RAM accepts request
ram_wen  out  1  RAM write
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_wmask  out  DATA_W/8  RAM byte mask
ram_rsp_valid  in  1  RAM response strobe, one cycle
ram_rdata  in  DATA_W  RAM read data
kb_push  in  1  scancode strobe from keyboard controller
kb_data  in  KB_W  scancode
kb_full  out  1  FIFO full
seg_wdata  out  SEG_W  segment display data

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, seg_wdata 0.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid, latch wen, addr, wdata and wmask, then decode:
    - RAM window → RAM_REQ.
    - KB or SEG window → resolve the peripheral access this cycle → RESP.
    - No window → RESP with err=1.
  - RAM_REQ: ram_req_valid=1 with the latched fields. On ram_req_ready → RAM_WAIT.
  - RAM_WAIT: on ram_rsp_valid, capture ram_rdata (reads only) → RESP.
  - RESP: rsp_valid=1 and response fields stable until rsp_ready → IDLE. req_ready=0 in every state except IDLE.
- Latency: peripheral access has rsp_valid one cycle after acceptance. RAM latency is 2 + request stall + RAM latency.
- Window test: base ≤ addr < base+len, evaluated at full ADDR_W with no wrap.
- KB +0 read: pops one entry and returns it zero-extended to DATA_W. Empty FIFO returns 0 with no error.
- KB +4 read: returns {full, count} zero-extended. count is log2(KB_DEPTH)+1 bits.
- Any write to the KB window: err=1, no side effect.
- SEG write: updates seg_wdata bytes selected by req_wmask[SEG_W/8-1:0], at the accept edge. SEG read returns seg_wdata zero-extended.
- FIFO:
  - Circular pointers with an extra wrap bit.
  - kb_push while full: scancode dropped, contents unchanged.
  - Push and pop in the same cycle: both take effect, count unchanged. When empty, a same-cycle push is not visible to that pop; the pop returns 0.
- Reset mid-transaction: aborts immediately. No response is issued after reset, and ram_req_valid drops asynchronously.

Optional Feature:
MMIO_TIMEOUT_EN: when defined, an 8+-bit counter runs in RAM_REQ and RAM_WAIT. If it reaches TIMEOUT, the FSM goes to RESP with err=1 and rdata=0, and any late ram_rsp_valid is ignored. When undefined, there is no counter and the bridge waits indefinitely.

Test Plan:
- Reset asserted during RAM_WAIT → all outputs 0 next edge; a later ram_rsp_valid produces no rsp_valid.
- Read 0x8000_0010 with RAM returning 64'hDEAD_BEEF_0123_4567 after 3 cycles → rsp_rdata matches, rsp_err=0, rsp_valid held while rsp_ready=0 for 2 cycles.
- Push 8'h1C, 8'hF0, 8'h1C; read 0xa000_0064 → 3. Read 0xa000_0060 three times → 1C, F0, 1C. Fourth read → 0.
- Push 9 scancodes with KB_DEPTH=8 → kb_full=1, 9th dropped, status reads {1,8}.
- Write 0xa000_0100 data 32'h1234_5678 mask 8'h0F, then mask 8'h01 data 0xAA → seg_wdata=32'h1234_56AA.
- Read 0x1000_0000 → rsp_err=1, rdata=0. With MMIO_TIMEOUT_EN and RAM never answering → err=1 after TIMEOUT cycles.
